// File: rtl/data_mem_ctrl_pkg.sv
// Shared load/store encodings and controller state types.
package data_mem_ctrl_pkg;

  // Access size encoding shared with the instruction decoder; 2'b10 is handled as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HW   = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // Data word is split into byte lanes; lane 3 carries bits 31:24 (big-endian).
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Halfwords need an even offset, words a zero offset; bytes are always aligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HW:   return ~offset[0];
      default:   return offset == 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_lane_align.sv
// Byte-lane steering: enables and store replication on the way out,
// lane select and sign/zero extension on the way back.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]                      size,
  input  logic [1:0]                      offset,
  input  logic                            zext,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] rdata,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] wdata,
  output logic [NUM_LANES-1:0]            be,
  output logic [NUM_LANES-1:0][VEC_W-1:0] wdata_rep,
  output logic [NUM_LANES*VEC_W-1:0]      rdata_ext
);

  logic             is_byte;
  logic             is_hw;
  logic [VEC_W-1:0] rbyte;
  logic [2*VEC_W-1:0] rhalf;

  assign is_byte = (size == SIZE_BYTE);
  assign is_hw   = (size == SIZE_HW);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    // Offset 0 is the most significant lane; halfword offset 2 selects the low pair.
    assign be[l] = is_byte ? (offset == 2'(NUM_LANES - 1 - l)) :
                   is_hw   ? (offset[1] == (l < 2)) : 1'b1;
    // Right-justified store data is copied into every lane it could land in.
    assign wdata_rep[l] = is_byte ? wdata[0] : is_hw ? wdata[l % 2] : wdata[l];
  end

  // Pick the addressed lane(s), then extend; zext=1 means unsigned load.
  always_comb begin
    rbyte = rdata[~offset];
    rhalf = offset[1] ? rdata[1:0] : rdata[3:2];
    if (is_byte)
      rdata_ext = {{((NUM_LANES-1)*VEC_W){~zext & rbyte[VEC_W-1]}}, rbyte};
    else if (is_hw)
      rdata_ext = {{((NUM_LANES-2)*VEC_W){~zext & rhalf[2*VEC_W-1]}}, rhalf};
    else
      rdata_ext = rdata;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store responder: turns decoder strobes into a req/ack RAM transaction,
// stalls the core until it completes and returns aligned, extended load data.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              re_in,
  input  logic              we_in,
  input  logic [1:0]        size_in,
  input  logic              signed_in,
  output logic [31:0]       rdata_out,
  output logic              stall_out,
  output logic              fault_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [3:0]        mem_be_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in,
  input  logic              mem_ack_in
);

  // Wide enough to hold TIMEOUT without wrapping before the compare.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  state_t           state, state_nxt;
  logic             strobe;
  logic             aligned;
  logic             timeout_hit;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             zext_q;
  logic [1:0]       al_size;
  logic [1:0]       al_off;
  logic             al_zext;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic [31:0]      al_rdata;
  logic [CNT_W-1:0] cnt;

  assign strobe      = re_in | we_in;
  assign aligned     = is_aligned(size_in, addr_in[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

  // The aligner sees the live request in IDLE and the captured one while BUSY.
  mem_lane_align u_align (
    .size      (al_size),
    .offset    (al_off),
    .zext      (al_zext),
    .rdata     (mem_rdata_in),
    .wdata     (wdata_in),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, combinational stall and aligner input select.
  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    al_size   = size_q;
    al_off    = off_q;
    al_zext   = zext_q;
    case (state)
      ST_IDLE: begin
        al_size = size_in;
        al_off  = addr_in[1:0];
        al_zext = signed_in;
        if (strobe && aligned) begin
          stall_out = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_out = 1'b1;
        if (mem_ack_in || timeout_hit) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, RAM handshake, load result and fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_out     <= '0;
      fault_out     <= 1'b0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_be_out    <= '0;
      mem_wdata_out <= '0;
      size_q        <= SIZE_BYTE;
      off_q         <= '0;
      zext_q        <= 1'b0;
      cnt           <= '0;
    end else begin
      fault_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe && aligned) begin
            // A store wins when both strobes are high.
            mem_req_out   <= 1'b1;
            mem_we_out    <= we_in;
            mem_addr_out  <= addr_in[ADDR_W+1:2];
            mem_be_out    <= al_be;
            mem_wdata_out <= al_wdata;
            size_q        <= size_in;
            off_q         <= addr_in[1:0];
            zext_q        <= signed_in;
            cnt           <= '0;
          end else if (strobe) begin
            fault_out <= 1'b1;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_ack_in) begin
            mem_req_out <= 1'b0;
            mem_we_out  <= 1'b0;
            if (!mem_we_out) rdata_out <= al_rdata;
          end else if (timeout_hit) begin
            mem_req_out <= 1'b0;
            mem_we_out  <= 1'b0;
            fault_out   <= 1'b1;
            rdata_out   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl with a behavioural reference model.
module tb_data_mem_ctrl;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    int          ack_at;   // cycle after the strobe in which ack is pulsed; 0 = never
  } acc_t;

  typedef struct {
    int          stall;
    int          req;
    int          faults;
    logic [3:0]  be;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata_done;
    logic [31:0] rdata_end;
  } obs_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    int          ack_at;
    int          stall;
    int          req;
    int          faults;
    logic [3:0]  be;
    logic [31:0] wd_exp;
    logic [31:0] rd_exp;
  } dvec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       addr_in, wdata_in;
  logic              re_in, we_in;
  logic [1:0]        size_in;
  logic              signed_in;
  logic [31:0]       rdata_out;
  logic              stall_out, fault_out;
  logic              mem_req_out, mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [3:0]        mem_be_out;
  logic [31:0]       mem_wdata_out, mem_rdata_in;
  logic              mem_ack_in;

  logic [31:0] ram    [0:1023];
  logic [31:0] shadow [0:1023];
  logic [31:0] last_rdata;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in), .re_in(re_in),
    .we_in(we_in), .size_in(size_in), .signed_in(signed_in), .rdata_out(rdata_out),
    .stall_out(stall_out), .fault_out(fault_out), .mem_req_out(mem_req_out),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in)
  );

  // Backing RAM: reads are combinational, byte-enabled writes land on ack.
  assign mem_rdata_in = ram[mem_addr_out];
  always @(posedge clk) begin
    if (mem_req_out && mem_ack_in && mem_we_out)
      for (int i = 0; i < 4; i++)
        if (mem_be_out[i]) ram[mem_addr_out][8*i +: 8] <= mem_wdata_out[8*i +: 8];
  end

  // Reference model: expected handshake and result straight from the access rules.
  task automatic model_access(input acc_t a, output obs_t e);
    int nb, off;
    logic [9:0] w;
    logic [31:0] f;
    e = '{default: 0};
    off = int'(a.addr[1:0]);
    w = a.addr[11:2];
    nb = (a.size == 2'd0) ? 1 : (a.size == 2'd1) ? 2 : 4;
    e.we = a.we;
    e.waddr = w;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(a.wdata >> (8 * (i % nb)));
    if ((off % nb) != 0) begin
      e.faults = 1;
    end else begin
      e.be = 4'(((1 << nb) - 1) << (4 - nb - off));
      if (a.ack_at == 0) begin
        e.stall = TIMEOUT + 1;
        e.req = TIMEOUT;
        e.faults = 1;
        last_rdata = 32'h0;
      end else begin
        e.stall = a.ack_at + 1;
        e.req = a.ack_at;
        if (a.we) begin
          for (int i = 0; i < 4; i++)
            if (e.be[i]) shadow[w][8*i +: 8] = e.wdata[8*i +: 8];
        end else begin
          f = (shadow[w] << (8 * off)) >> (32 - 8 * nb);
          if (nb < 4 && !a.sgn && f[8*nb-1]) f = f | (32'hFFFF_FFFF << (8 * nb));
          last_rdata = f;
        end
      end
    end
    e.rdata_done = last_rdata;
    e.rdata_end = last_rdata;
  endtask

  // Drives one access from just after a posedge and observes a fixed 9-cycle window.
  task automatic run_access(input acc_t a, output obs_t o);
    logic seen;
    o = '{default: 0};
    seen = 1'b0;
    addr_in = a.addr; wdata_in = a.wdata; re_in = a.re; we_in = a.we;
    size_in = a.size; signed_in = a.sgn;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin re_in = 1'b0; we_in = 1'b0; end
      mem_ack_in = (c > 0) && (c == a.ack_at);
      @(negedge clk);
      if (stall_out) o.stall++;
      else if (c > 0 && !seen) begin seen = 1'b1; o.rdata_done = rdata_out; end
      if (mem_req_out) begin
        if (o.req == 0) begin
          o.be = mem_be_out; o.we = mem_we_out; o.waddr = mem_addr_out; o.wdata = mem_wdata_out;
        end
        o.req++;
      end
      if (fault_out) o.faults++;
      @(posedge clk); #1;
    end
    mem_ack_in = 1'b0;
    o.rdata_end = rdata_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr_in = '0; wdata_in = '0; re_in = 1'b0; we_in = 1'b0;
    size_in = '0; signed_in = 1'b0; mem_ack_in = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    checks += 8;
    if (rdata_out !== 32'h0)  begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_out); end
    if (fault_out !== 1'b0)   begin failures++; $display("FAIL reset_fault got=%b exp=0", fault_out); end
    if (mem_req_out !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req_out); end
    if (mem_we_out !== 1'b0)  begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we_out); end
    if (mem_be_out !== 4'h0)  begin failures++; $display("FAIL reset_be got=%b exp=0", mem_be_out); end
    if (mem_addr_out !== '0)  begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr_out); end
    if (mem_wdata_out !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata_out); end
    if (stall_out !== 1'b0)   begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dvec_t dv [8];
    acc_t a;
    obs_t o, e;
    ram[10'h41] = 32'h11A2_3344; shadow[10'h41] = 32'h11A2_3344;
    ram[10'h42] = 32'h1234_8001; shadow[10'h42] = 32'h1234_8001;
    //        addr          wdata          re    we    sz     sgn ack st rq ft be       wd_exp         rd_exp
    dv[0] = '{32'h0000_0105, 32'h0,        1'b1, 1'b0, 2'b00, 1'b0, 2, 3, 2, 0, 4'b0100, 32'h0,         32'hFFFF_FFA2};
    dv[1] = '{32'h0000_0105, 32'h0,        1'b1, 1'b0, 2'b00, 1'b1, 2, 3, 2, 0, 4'b0100, 32'h0,         32'h0000_00A2};
    dv[2] = '{32'h0000_010A, 32'h0,        1'b1, 1'b0, 2'b01, 1'b0, 1, 2, 1, 0, 4'b0011, 32'h0,         32'hFFFF_8001};
    dv[3] = '{32'h0000_010E, 32'hDEADBEEF, 1'b0, 1'b1, 2'b01, 1'b0, 3, 4, 3, 0, 4'b0011, 32'hBEEF_BEEF, 32'hFFFF_8001};
    dv[4] = '{32'h0000_0110, 32'hCAFEF00D, 1'b0, 1'b1, 2'b11, 1'b0, 4, 5, 4, 0, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_8001};
    dv[5] = '{32'h0000_0112, 32'h0,        1'b1, 1'b0, 2'b11, 1'b0, 1, 0, 0, 1, 4'b0000, 32'h0,         32'hFFFF_8001};
    dv[6] = '{32'h0000_0104, 32'h0,        1'b1, 1'b0, 2'b11, 1'b0, 0, 5, 4, 1, 4'b1111, 32'h0,         32'h0000_0000};
    dv[7] = '{32'h0000_010E, 32'h0,        1'b1, 1'b0, 2'b01, 1'b1, 1, 2, 1, 0, 4'b0011, 32'h0,         32'h0000_BEEF};
    for (int n = 0; n < 8; n++) begin
      a = '{dv[n].addr, dv[n].wdata, dv[n].re, dv[n].we, dv[n].size, dv[n].sgn, dv[n].ack_at};
      run_access(a, o);
      model_access(a, e);
      checks += 4;
      if (o.stall !== dv[n].stall)
        begin failures++; $display("FAIL dir%0d_stall got=%0d exp=%0d", n, o.stall, dv[n].stall); end
      if (o.req !== dv[n].req)
        begin failures++; $display("FAIL dir%0d_req got=%0d exp=%0d", n, o.req, dv[n].req); end
      if (o.faults !== dv[n].faults)
        begin failures++; $display("FAIL dir%0d_fault got=%0d exp=%0d", n, o.faults, dv[n].faults); end
      if (o.rdata_end !== dv[n].rd_exp)
        begin failures++; $display("FAIL dir%0d_rdata got=%h exp=%h", n, o.rdata_end, dv[n].rd_exp); end
      if (dv[n].req > 0) begin
        checks += 2;
        if (o.be !== dv[n].be)
          begin failures++; $display("FAIL dir%0d_be got=%b exp=%b", n, o.be, dv[n].be); end
        if (o.we !== dv[n].we)
          begin failures++; $display("FAIL dir%0d_we got=%b exp=%b", n, o.we, dv[n].we); end
        if (dv[n].we) begin
          checks++;
          if (o.wdata !== dv[n].wd_exp)
            begin failures++; $display("FAIL dir%0d_wdata got=%h exp=%h", n, o.wdata, dv[n].wd_exp); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    acc_t a;
    obs_t o, e;
    addr_in = 32'h0000_0104; re_in = 1'b1; we_in = 1'b0; size_in = 2'b11; signed_in = 1'b0;
    mem_ack_in = 1'b0;
    @(posedge clk); #1;
    re_in = 1'b0;
    @(posedge clk); #1;
    #3 rst = 1'b1;
    #1;
    checks += 2;
    if (mem_req_out !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", mem_req_out); end
    if (stall_out !== 1'b0)   begin failures++; $display("FAIL midrst_stall got=%b exp=0", stall_out); end
    @(negedge clk);
    rst = 1'b0;
    last_rdata = 32'h0;
    @(posedge clk); #1;
    mem_ack_in = 1'b1;
    @(posedge clk); #1;
    mem_ack_in = 1'b0;
    @(negedge clk);
    checks += 4;
    if (mem_req_out !== 1'b0) begin failures++; $display("FAIL lateack_req got=%b exp=0", mem_req_out); end
    if (stall_out !== 1'b0)   begin failures++; $display("FAIL lateack_stall got=%b exp=0", stall_out); end
    if (rdata_out !== 32'h0)  begin failures++; $display("FAIL lateack_rdata got=%h exp=0", rdata_out); end
    if (fault_out !== 1'b0)   begin failures++; $display("FAIL lateack_fault got=%b exp=0", fault_out); end
    @(posedge clk); #1;
    // Both strobes high: must be a store.
    a = '{32'h0000_0120, 32'h0BAD_F00D, 1'b1, 1'b1, 2'b11, 1'b0, 1};
    run_access(a, o);
    model_access(a, e);
    checks += 4;
    if (o.we !== 1'b1)           begin failures++; $display("FAIL rewe_we got=%b exp=1", o.we); end
    if (o.be !== 4'b1111)        begin failures++; $display("FAIL rewe_be got=%b exp=1111", o.be); end
    if (o.wdata !== 32'h0BADF00D) begin failures++; $display("FAIL rewe_wdata got=%h exp=0badf00d", o.wdata); end
    if (o.rdata_end !== 32'h0)   begin failures++; $display("FAIL rewe_rdata got=%h exp=0", o.rdata_end); end
    a = '{32'h0000_0120, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 2};
    run_access(a, o);
    model_access(a, e);
    checks++;
    if (o.rdata_end !== 32'h0BADF00D)
      begin failures++; $display("FAIL rewe_readback got=%h exp=0badf00d", o.rdata_end); end
  endtask

  task automatic test_random();
    acc_t a;
    obs_t o, e;
    logic [31:0] r;
    int k;
    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      a.addr = {r[31:12], 7'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      a.wdata = $urandom();
      k = $urandom_range(0, 2);
      a.re = (k != 1);
      a.we = (k != 0);
      a.size = 2'($urandom_range(0, 3));
      a.sgn = 1'($urandom_range(0, 1));
      a.ack_at = $urandom_range(0, TIMEOUT);
      run_access(a, o);
      model_access(a, e);
      checks += 5;
      if (o.stall !== e.stall)
        begin failures++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", n, o.stall, e.stall); end
      if (o.req !== e.req)
        begin failures++; $display("FAIL rnd%0d_req got=%0d exp=%0d", n, o.req, e.req); end
      if (o.faults !== e.faults)
        begin failures++; $display("FAIL rnd%0d_fault got=%0d exp=%0d", n, o.faults, e.faults); end
      if (o.rdata_done !== e.rdata_done)
        begin failures++; $display("FAIL rnd%0d_rdata_done got=%h exp=%h", n, o.rdata_done, e.rdata_done); end
      if (o.rdata_end !== e.rdata_end)
        begin failures++; $display("FAIL rnd%0d_rdata_end got=%h exp=%h", n, o.rdata_end, e.rdata_end); end
      if (e.req > 0) begin
        checks += 3;
        if (o.be !== e.be)
          begin failures++; $display("FAIL rnd%0d_be got=%b exp=%b", n, o.be, e.be); end
        if (o.we !== e.we)
          begin failures++; $display("FAIL rnd%0d_we got=%b exp=%b", n, o.we, e.we); end
        if (o.waddr !== e.waddr)
          begin failures++; $display("FAIL rnd%0d_addr got=%h exp=%h", n, o.waddr, e.waddr); end
        if (a.we) begin
          checks++;
          if (o.wdata !== e.wdata)
            begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, o.wdata, e.wdata); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom();
      shadow[i] = ram[i];
    end
    test_reset();
    test_directed();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
